// File: rtl/ddrx_cmd_arb.sv
// ddrx_cmd_arb: merges NUM_CH read/write command streams into one registered command port
// using round-robin arbitration. Define DDRX_CMD_ARB_ROWHIT_EN to prefer last-row hits.
module ddrx_cmd_arb #(
   parameter int NUM_CH      = 4,
   parameter int ADDR_W      = 32,
   parameter int LEN_W       = 8,
   parameter int ROW_LSB     = 13,
   parameter int ROW_W       = 14,
   parameter int MAX_HIT_RUN = 4,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     core_clk,
   input  logic                     core_rst,
   input  logic [NUM_CH-1:0]        ch_valid,
   output logic [NUM_CH-1:0]        ch_ready,
   input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
   input  logic [NUM_CH-1:0]        ch_write,
   input  logic [NUM_CH*LEN_W-1:0]  ch_len,
   output logic                     cmd_valid,
   input  logic                     cmd_ready,
   output logic [ADDR_W-1:0]        cmd_addr,
   output logic                     cmd_write,
   output logic [LEN_W-1:0]         cmd_len,
   output logic [CH_W-1:0]          cmd_ch
);

   // Valid/ready: a transfer happens on a rising edge where both are high; the
   // sender holds valid and payload stable until accepted.

   logic [ADDR_W-1:0] addr_a [NUM_CH];
   logic [LEN_W-1:0]  len_a  [NUM_CH];
   logic [ROW_W-1:0]  row_a  [NUM_CH];

   for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
      assign addr_a[i] = ch_addr[i*ADDR_W +: ADDR_W];
      assign len_a[i]  = ch_len[i*LEN_W +: LEN_W];
      assign row_a[i]  = addr_a[i][ROW_LSB +: ROW_W];
   end

   logic            load;
   logic            any_valid;
   logic            grant;
   logic [CH_W-1:0] rr_ptr;
   logic [CH_W-1:0] rr_win;
   logic [CH_W-1:0] win;
   logic [CH_W-1:0] next_ptr;
   logic [ROW_W-1:0] last_row;

   assign load = ~cmd_valid | cmd_ready;

   // Scan offsets from the far end so the channel closest to rr_ptr is written last and wins.
   always_comb begin : rr_scan
      int idx;
      logic [CH_W-1:0] idx_c;
      idx       = 0;
      idx_c     = '0;
      any_valid = 1'b0;
      rr_win    = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         idx_c = CH_W'(idx);
         if (ch_valid[idx_c]) begin
            any_valid = 1'b1;
            rr_win    = idx_c;
         end
      end
   end

`ifdef DDRX_CMD_ARB_ROWHIT_EN
   localparam int HR_W = $clog2(MAX_HIT_RUN + 1);
   localparam logic [HR_W-1:0] HR_MAX = HR_W'(MAX_HIT_RUN);

   logic [HR_W-1:0] hit_run;
   logic            any_hit;
   logic            hit_ok;
   logic [CH_W-1:0] hit_win;

   always_comb begin : hit_scan
      int idx;
      logic [CH_W-1:0] idx_c;
      idx     = 0;
      idx_c   = '0;
      any_hit = 1'b0;
      hit_win = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         idx_c = CH_W'(idx);
         if (ch_valid[idx_c] && (row_a[idx_c] == last_row)) begin
            any_hit = 1'b1;
            hit_win = idx_c;
         end
      end
   end

   // Once the run limit is reached one plain round-robin grant is forced, bounding starvation.
   assign hit_ok = any_hit && (hit_run < HR_MAX);
   assign win    = hit_ok ? hit_win : rr_win;

   always_ff @(posedge core_clk or posedge core_rst) begin
      if (core_rst) begin
         hit_run <= '0;
      end else if (load) begin
         if (any_valid && hit_ok) hit_run <= hit_run + 1'b1;
         else                     hit_run <= '0;
      end
   end
`else
   logic unused_cfg;

   assign win        = rr_win;
   assign unused_cfg = (^last_row) ^ (MAX_HIT_RUN > 0);
`endif

   assign grant    = load & any_valid & ~core_rst;
   assign next_ptr = (int'(win) == NUM_CH - 1) ? '0 : win + 1'b1;

   always_comb begin
      ch_ready = '0;
      if (grant) ch_ready[win] = 1'b1;
   end

   // Output register: replaced on the same edge it is consumed, so no bubble at full rate.
   always_ff @(posedge core_clk or posedge core_rst) begin
      if (core_rst) begin
         cmd_valid <= 1'b0;
         cmd_addr  <= '0;
         cmd_write <= 1'b0;
         cmd_len   <= '0;
         cmd_ch    <= '0;
         rr_ptr    <= '0;
         last_row  <= '0;
      end else if (load) begin
         if (any_valid) begin
            cmd_valid <= 1'b1;
            cmd_addr  <= addr_a[win];
            cmd_write <= ch_write[win];
            cmd_len   <= len_a[win];
            cmd_ch    <= win;
            rr_ptr    <= next_ptr;
            last_row  <= row_a[win];
         end else begin
            cmd_valid <= 1'b0;
         end
      end
   end

endmodule
